alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Parametrised execute-stage unit for the RISC-V pipeline. It merges ALU control decode (ALUOp + Fun6 to a 4-bit operation code) with a registered ALU datapath and an iterative multi-cycle multiplier. Operands enter and results leave through valid/ready handshakes, so the pipeline can stall on multi-cycle operations. It is the successor to the combinational ALU control unit: wider, configurable, and able to stall.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64
MUL_EN, 1, 1 = iterative MUL supported; 0 = MUL decodes as illegal
OPW, 4, operation-code width (fixed 4; exposed for the debug port)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and opcode valid
in_ready  out  1  unit can accept this cycle
alu_op  in  2  ALUOp from main control
fun6  in  6  function field
op_a  in  XLEN  operand A
op_b  in  XLEN  operand B
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  XLEN  registered result
zero  out  1  result == 0 (registered with result)
illegal  out  1  op was undecodable; result forced to 0
operation  out  OPW  decoded code of the op held in the output register

Behaviour:
- Decode, combinational on the input side:
  - alu_op 00 -> ADD (0010); 01 -> SUB (0110); 11 -> illegal.
  - alu_op 10 selects by fun6:
    - 000000 ADD 0010; 000010 SUB 0110; 000100 AND 0000; 000101 OR 0001; 000110 XOR 0011
    - 000111 SLT (signed) 0111; 001000 SLL 1000; 001001 SRL 1001; 001010 SRA 1010
    - 001100 MUL 1100
    - any other fun6 -> illegal.
- Arithmetic is modulo 2^XLEN. Shift amount is op_b[$clog2(XLEN)-1:0]. SLT result is zero-extended 0/1. MUL returns the low XLEN bits of the product.
- An illegal op has operation=1111, result=0, zero=1, illegal=1, and single-cycle timing.
- Accept condition: a transfer occurs when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- FSM states:
  - IDLE:
    - accept of a non-MUL op -> output register loads on the same edge; out_valid=1 next cycle; stay IDLE.
    - accept of MUL -> latch operands, clear accumulator, count=0 -> BUSY.
  - BUSY: one shift-add step per cycle over bits of op_b, LSB first. After XLEN steps, load the output register and set out_valid -> IDLE. Total latency from accept to out_valid is XLEN+1 cycles. in_ready=0 throughout.
  - The output register holds result/zero/illegal/operation stable while out_valid && !out_ready.
- Output handshake:
  - out_valid drops on the edge where out_ready=1, unless a new op is accepted on the same edge; then it stays 1 with new data.
  - Back-to-back single-cycle ops give full throughput at one per cycle.
- MUL completion while the output is still held: the BUSY exit waits until (!out_valid || out_ready), so no result is overwritten. Entering BUSY requires in_ready, which guarantees the output slot is free, so this case cannot occur.
- Reset (async assert, sync release): state=IDLE, out_valid=0, result=0, zero=0, illegal=0, operation=0000, counter=0. Assertion mid-MUL aborts the operation with no output.
- in_valid=1 while in_ready=0: inputs are ignored and the sender must hold them.
- Inputs are sampled only on the accept edge, so operand changes during BUSY have no effect.

Test Plan:
1. Reset, then alu_op=00, op_a=5, op_b=7 -> one cycle later out_valid=1, result=12, operation=0010, zero=0.
2. alu_op=01, op_a=op_b=0x1234 -> result=0, zero=1, operation=0110. Then alu_op=10, fun6=000111, op_a=0xFFFFFFFF, op_b=1 -> result=1 (signed -1<1).
3. fun6=001010 (SRA), op_a=0x80000000, op_b=0x24 -> shift 4, result=0xF8000000. Fun6 sweep over 000000/000010/000100/000101 with A=0xC, B=0xA -> 22, 2, 8, 14.
4. MUL with op_a=0xFFFF, op_b=0x10001, out_ready=1 -> in_ready low for 32 cycles; out_valid at cycle 33 after accept; result=0xFFFFFFFF. Repeat with MUL_EN=0 -> illegal=1 after 1 cycle.
5. Back-pressure: out_ready=0 with 3 ops offered -> first result held stable, in_ready=0. Release out_ready -> results emerge in order, one per cycle, none dropped.
6. Assert rst_n=0 at cycle 10 of a MUL -> outputs zero immediately. After release, no stale result appears and the first new ADD completes normally. alu_op=11 -> operation=1111, illegal=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage with ALU control decode, a registered ALU
// and an iterative shift-add multiplier behind valid/ready handshakes.
module alu_exec_unit #(
    parameter int XLEN   = 32,
    parameter int MUL_EN = 1,
    parameter int OPW    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [5:0]      fun6,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic [OPW-1:0]  operation
);
    localparam int SW = $clog2(XLEN);
    localparam logic [SW:0] CNT_DONE = (SW+1)'(XLEN);

    localparam logic [OPW-1:0] OP_AND = OPW'(4'b0000);
    localparam logic [OPW-1:0] OP_OR  = OPW'(4'b0001);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0010);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4'b0011);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0110);
    localparam logic [OPW-1:0] OP_SLT = OPW'(4'b0111);
    localparam logic [OPW-1:0] OP_SLL = OPW'(4'b1000);
    localparam logic [OPW-1:0] OP_SRL = OPW'(4'b1001);
    localparam logic [OPW-1:0] OP_SRA = OPW'(4'b1010);
    localparam logic [OPW-1:0] OP_MUL = OPW'(4'b1100);
    localparam logic [OPW-1:0] OP_ILL = OPW'(4'b1111);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_n;
    logic [OPW-1:0]  dec_op;
    logic            dec_ill;
    logic            dec_mul;
    logic [XLEN-1:0] alu_res;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] mul_a;
    logic [XLEN-1:0] mul_b;
    logic [XLEN-1:0] acc;
    logic [SW:0]     cnt;
    logic            accept;
    logic            out_free;
    logic            mul_done;

    always_comb begin
        dec_op = OP_ILL;
        unique case (alu_op)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (fun6)
                    6'b000000: dec_op = OP_ADD;
                    6'b000010: dec_op = OP_SUB;
                    6'b000100: dec_op = OP_AND;
                    6'b000101: dec_op = OP_OR;
                    6'b000110: dec_op = OP_XOR;
                    6'b000111: dec_op = OP_SLT;
                    6'b001000: dec_op = OP_SLL;
                    6'b001001: dec_op = OP_SRL;
                    6'b001010: dec_op = OP_SRA;
                    6'b001100: dec_op = (MUL_EN != 0) ? OP_MUL : OP_ILL;
                    default:   dec_op = OP_ILL;
                endcase
            end
            2'b11: dec_op = OP_ILL;
        endcase
    end

    assign dec_ill = (dec_op == OP_ILL);
    assign dec_mul = (dec_op == OP_MUL);
    assign shamt   = op_b[SW-1:0];

    // Illegal ops fall through to zero so result/zero need no extra mux
    always_comb begin
        alu_res = '0;
        case (dec_op)
            OP_ADD: alu_res = op_a + op_b;
            OP_SUB: alu_res = op_a - op_b;
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SLT: alu_res = {{(XLEN-1){1'b0}},
                               ($signed(op_a) < $signed(op_b))};
            OP_SLL: alu_res = op_a << shamt;
            OP_SRL: alu_res = op_a >> shamt;
            OP_SRA: alu_res = $signed(op_a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign mul_done = (state == BUSY) && (cnt == CNT_DONE) && out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept && dec_mul) state_n = BUSY;
            BUSY: if (mul_done) state_n = IDLE;
        endcase
    end

    // One shift-add step per cycle, multiplier bits consumed LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept && dec_mul) begin
            mul_a <= op_a;
            mul_b <= op_b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == BUSY && cnt != CNT_DONE) begin
            if (mul_b[0]) acc <= acc + mul_a;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            cnt   <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            operation <= '0;
        end else if (accept && !dec_mul) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            zero      <= (alu_res == '0);
            illegal   <= dec_ill;
            operation <= dec_op;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            result    <= acc;
            zero      <= (acc == '0);
            illegal   <= 1'b0;
            operation <= OP_MUL;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit: decode, ALU ops, iterative MUL,
// back-pressure and reset abort.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_valid0;
    logic        in_ready, in_ready0;
    logic [1:0]  alu_op;
    logic [5:0]  fun6;
    logic [31:0] op_a, op_b;
    logic        out_valid, out_valid0;
    logic        out_ready;
    logic [31:0] result, result0;
    logic        zero, zero0;
    logic        illegal, illegal0;
    logic [3:0]  operation, operation0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .MUL_EN(1), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .fun6(fun6), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal),
        .operation(operation)
    );

    alu_exec_unit #(.XLEN(32), .MUL_EN(0), .OPW(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .alu_op(alu_op), .fun6(fun6), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid0), .out_ready(out_ready),
        .result(result0), .zero(zero0), .illegal(illegal0),
        .operation(operation0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        alu_op   = op;
        fun6     = f;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_valid0 = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; fun6 = '0; op_a = '0; op_b = '0;
        repeat (3) tick();
        nvec++;
        if ({out_valid, result, zero, illegal, operation, in_ready}
            !== {1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 1'b1}) begin
            $display("FAIL reset: got v=%b r=%h z=%b i=%b op=%b rdy=%b, want 0/0/0/0/0000/1",
                     out_valid, result, zero, illegal, operation, in_ready);
            nerr++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        offer(2'b00, 6'b0, 32'd5, 32'd7);
        tick();
        in_valid = 1'b0;
        nvec++;
        if ({out_valid, result, zero, illegal, operation}
            !== {1'b1, 32'd12, 1'b0, 1'b0, 4'b0010}) begin
            $display("FAIL add: got v=%b r=%h z=%b op=%b, want 1/0000000c/0/0010",
                     out_valid, result, zero, operation);
            nerr++;
        end
        tick();
        nvec++;
        if (out_valid !== 1'b0) begin
            $display("FAIL add_drain: got out_valid=%b, want 0", out_valid);
            nerr++;
        end
    endtask

    task automatic test_sub_slt();
        offer(2'b01, 6'b0, 32'h1234, 32'h1234);
        tick();
        nvec++;
        if ({out_valid, result, zero, operation}
            !== {1'b1, 32'h0, 1'b1, 4'b0110}) begin
            $display("FAIL sub_zero: got v=%b r=%h z=%b op=%b, want 1/0/1/0110",
                     out_valid, result, zero, operation);
            nerr++;
        end
        offer(2'b10, 6'b000111, 32'hFFFF_FFFF, 32'h1);
        tick();
        in_valid = 1'b0;
        nvec++;
        if ({out_valid, result, zero, operation}
            !== {1'b1, 32'h1, 1'b0, 4'b0111}) begin
            $display("FAIL slt: got v=%b r=%h z=%b op=%b, want 1/1/0/0111",
                     out_valid, result, zero, operation);
            nerr++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  t_op  [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                  2'b10, 2'b10, 2'b10, 2'b10};
        logic [5:0]  t_f   [9] = '{6'b001010, 6'b000000, 6'b000010,
                                  6'b000100, 6'b000101, 6'b000110,
                                  6'b001000, 6'b001001, 6'b000111};
        logic [31:0] t_a   [9] = '{32'h8000_0000, 32'hC, 32'hC, 32'hC,
                                  32'hC, 32'hC, 32'hC, 32'h8000_0000,
                                  32'h5};
        logic [31:0] t_b   [9] = '{32'h24, 32'hA, 32'hA, 32'hA, 32'hA,
                                  32'hA, 32'hA, 32'h4, 32'h3};
        logic [31:0] t_r   [9] = '{32'hF800_0000, 32'd22, 32'd2, 32'd8,
                                  32'd14, 32'd6, 32'h3000, 32'h0800_0000,
                                  32'h0};
        logic [3:0]  t_o   [9] = '{4'b1010, 4'b0010, 4'b0110, 4'b0000,
                                  4'b0001, 4'b0011, 4'b1000, 4'b1001,
                                  4'b0111};
        for (int i = 0; i < 9; i++) begin
            offer(t_op[i], t_f[i], t_a[i], t_b[i]);
            nvec++;
            if (in_ready !== 1'b1) begin
                $display("FAIL b2b_ready[%0d]: got in_ready=%b, want 1",
                         i, in_ready);
                nerr++;
            end
            tick();
            nvec++;
            if ({out_valid, result, zero, illegal, operation}
                !== {1'b1, t_r[i], (t_r[i] == 32'h0), 1'b0, t_o[i]}) begin
                $display("FAIL b2b[%0d]: got v=%b r=%h z=%b op=%b, want r=%h op=%b",
                         i, out_valid, result, zero, operation, t_r[i], t_o[i]);
                nerr++;
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mul(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        int  cyc = 0;
        bit  rdy_seen = 0;
        offer(2'b10, 6'b001100, a, b);
        tick();
        in_valid = 1'b0;
        op_a = 32'hDEAD_BEEF;
        op_b = 32'h1234_5678;
        while (!out_valid && cyc < 100) begin
            if (in_ready) rdy_seen = 1;
            tick();
            cyc++;
        end
        nvec++;
        if (cyc !== 33 || rdy_seen) begin
            $display("FAIL mul_latency: got %0d cycles rdy_seen=%0d, want 33/0",
                     cyc, rdy_seen);
            nerr++;
        end
        nvec++;
        if ({out_valid, result, zero, illegal, operation}
            !== {1'b1, exp, (exp == 32'h0), 1'b0, 4'b1100}) begin
            $display("FAIL mul_result: got v=%b r=%h z=%b op=%b, want r=%h op=1100",
                     out_valid, result, zero, operation, exp);
            nerr++;
        end
        tick();
    endtask

    task automatic test_mul_disabled();
        alu_op = 2'b10; fun6 = 6'b001100;
        op_a = 32'hFFFF; op_b = 32'h10001;
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        nvec++;
        if ({out_valid0, result0, zero0, illegal0, operation0}
            !== {1'b1, 32'h0, 1'b1, 1'b1, 4'b1111}) begin
            $display("FAIL mul_disabled: got v=%b r=%h z=%b i=%b op=%b, want 1/0/1/1/1111",
                     out_valid0, result0, zero0, illegal0, operation0);
            nerr++;
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        offer(2'b00, 6'b0, 32'd1, 32'd2);
        tick();
        offer(2'b01, 6'b0, 32'd10, 32'd3);
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if ({out_valid, result, in_ready} !== {1'b1, 32'd3, 1'b0}) begin
                $display("FAIL bp_hold[%0d]: got v=%b r=%h rdy=%b, want 1/3/0",
                         i, out_valid, result, in_ready);
                nerr++;
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        nvec++;
        if (in_ready !== 1'b1) begin
            $display("FAIL bp_release_ready: got %b, want 1", in_ready);
            nerr++;
        end
        tick();
        nvec++;
        if ({out_valid, result, operation} !== {1'b1, 32'd7, 4'b0110}) begin
            $display("FAIL bp_second: got v=%b r=%h op=%b, want 1/7/0110",
                     out_valid, result, operation);
            nerr++;
        end
        offer(2'b10, 6'b000110, 32'hF0, 32'hFF);
        tick();
        in_valid = 1'b0;
        nvec++;
        if ({out_valid, result, operation} !== {1'b1, 32'h0F, 4'b0011}) begin
            $display("FAIL bp_third: got v=%b r=%h op=%b, want 1/0f/0011",
                     out_valid, result, operation);
            nerr++;
        end
        tick();
        nvec++;
        if (out_valid !== 1'b0) begin
            $display("FAIL bp_drain: got out_valid=%b, want 0", out_valid);
            nerr++;
        end
    endtask

    task automatic test_reset_mid_mul();
        int stale = 0;
        offer(2'b10, 6'b001100, 32'hFFFF, 32'h10001);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({out_valid, result, zero, illegal, operation, in_ready}
            !== {1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 1'b1}) begin
            $display("FAIL mid_mul_reset: got v=%b r=%h z=%b i=%b op=%b rdy=%b, want 0/0/0/0/0000/1",
                     out_valid, result, zero, illegal, operation, in_ready);
            nerr++;
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) stale++;
            tick();
        end
        nvec++;
        if (stale !== 0) begin
            $display("FAIL stale_result: got %0d valid cycles, want 0", stale);
            nerr++;
        end
        offer(2'b00, 6'b0, 32'd3, 32'd4);
        tick();
        nvec++;
        if ({out_valid, result, operation} !== {1'b1, 32'd7, 4'b0010}) begin
            $display("FAIL post_reset_add: got v=%b r=%h op=%b, want 1/7/0010",
                     out_valid, result, operation);
            nerr++;
        end
        offer(2'b11, 6'b0, 32'd9, 32'd9);
        tick();
        in_valid = 1'b0;
        nvec++;
        if ({out_valid, result, zero, illegal, operation}
            !== {1'b1, 32'h0, 1'b1, 1'b1, 4'b1111}) begin
            $display("FAIL aluop11: got v=%b r=%h z=%b i=%b op=%b, want 1/0/1/1/1111",
                     out_valid, result, zero, illegal, operation);
            nerr++;
        end
        offer(2'b10, 6'b111111, 32'd9, 32'd9);
        tick();
        in_valid = 1'b0;
        nvec++;
        if ({result, illegal, operation} !== {32'h0, 1'b1, 4'b1111}) begin
            $display("FAIL bad_fun6: got r=%h i=%b op=%b, want 0/1/1111",
                     result, illegal, operation);
            nerr++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_back_to_back();
        test_mul(32'hFFFF, 32'h10001, 32'hFFFF_FFFF);
        test_mul(32'h1234_5678, 32'h0, 32'h0);
        test_mul(32'd7, 32'd6, 32'd42);
        test_mul_disabled();
        test_backpressure();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
